// File: rtl/sfx_mixer_if.sv
// Signal bundle between the game logic / melody generator and the audio
// output stage. The game side is the master; the mixer is the slave.
interface sfx_mixer_if;
    logic       melody_in;   // square wave from the melody generator
    logic       sfx_lock;    // 1-cycle pulse: piece locked
    logic       sfx_clear;   // 1-cycle pulse: line(s) cleared
    logic [2:0] volume;      // 0 = silent .. 7 = full
    logic       mute;        // level, forces the speaker low
    logic       spkr_out;    // registered speaker drive
    logic       sfx_active;  // high while an effect owns the output

    modport master (
        output melody_in, sfx_lock, sfx_clear, volume, mute,
        input  spkr_out, sfx_active
    );

    modport slave (
        input  melody_in, sfx_lock, sfx_clear, volume, mute,
        output spkr_out, sfx_active
    );
endinterface

// File: rtl/sfx_mixer.sv
// Audio output stage. Plays short sound effects (piece-lock blip, three-note
// line-clear arpeggio) that duck the incoming melody, then gates the result
// with mute and a 7-step PWM volume before driving the speaker pin.
module sfx_mixer #(
    parameter int FCLK    = 50_000_000,  // clock frequency, Hz
    parameter int LOCK_MS = 100,         // piece-lock blip length, ms
    parameter int STEP_MS = 80           // length of each arpeggio note, ms
) (
    input  logic        clk,
    input  logic        reset_n,
    sfx_mixer_if.slave  bus
);

    // ------------------------------------------------------------------
    // Elaboration-time constants
    // ------------------------------------------------------------------
    localparam int DIV     = FCLK / 1000;            // clocks per 1 ms tick
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam int HP_LOCK = FCLK / (2 * 220);       // 220 Hz lock tone
    localparam int HP_C0   = FCLK / (2 * 523);       // C5
    localparam int HP_C1   = FCLK / (2 * 659);       // E5
    localparam int HP_C2   = FCLK / (2 * 784);       // G5
    localparam int TONE_W  = $clog2(HP_LOCK);        // lowest note has the longest half-period

    localparam int MS_MAX  = (LOCK_MS > STEP_MS) ? LOCK_MS : STEP_MS;
    localparam int MS_W    = $clog2(MS_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(DIV - 1);
    localparam logic [TONE_W-1:0] HP_LOCK_LAST = TONE_W'(HP_LOCK - 1);
    localparam logic [TONE_W-1:0] HP_C0_LAST   = TONE_W'(HP_C0 - 1);
    localparam logic [TONE_W-1:0] HP_C1_LAST   = TONE_W'(HP_C1 - 1);
    localparam logic [TONE_W-1:0] HP_C2_LAST   = TONE_W'(HP_C2 - 1);
    localparam logic [MS_W-1:0]   LOCK_LAST    = MS_W'(LOCK_MS - 1);
    localparam logic [MS_W-1:0]   STEP_LAST    = MS_W'(STEP_MS - 1);
    localparam logic [2:0]        PWM_LAST     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_CLR0,
        ST_CLR1,
        ST_CLR2
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic                restart;      // fresh entry into LOCK or CLR0
    logic                note_change;  // any state change or restart
    logic                step_done;    // last tick of the current note

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [MS_W-1:0]     ms_cnt;
    logic [MS_W-1:0]     dur_last;
    logic [TONE_W-1:0]   tone_cnt;
    logic [TONE_W-1:0]   hp_last;
    logic                sfx_sq;

    logic [2:0]          pwm_cnt;
    logic                gate;
    logic                tone;
    logic                spkr_q;
    logic                active_q;

    // ------------------------------------------------------------------
    // Decode of the current note: duration and half-period
    // ------------------------------------------------------------------
    // Per-state duration and tone half-period, plus the terminal-tick flag.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned and infers a latch.
        hp_last  = HP_LOCK_LAST;
        dur_last = STEP_LAST;
        case (state_q)
            ST_LOCK: begin
                hp_last  = HP_LOCK_LAST;
                dur_last = LOCK_LAST;
            end
            ST_CLR0: hp_last = HP_C0_LAST;
            ST_CLR1: hp_last = HP_C1_LAST;
            ST_CLR2: hp_last = HP_C2_LAST;
            default: hp_last = HP_LOCK_LAST;
        endcase
        tick      = (div_cnt == DIV_LAST);
        step_done = tick && (ms_cnt == dur_last);
    end

    // ------------------------------------------------------------------
    // Effect sequencer
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats lock; lock is ignored during the arpeggio.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sfx_clear) begin
                    state_d = ST_CLR0;
                    restart = 1'b1;
                end else if (bus.sfx_lock) begin
                    state_d = ST_LOCK;
                    restart = 1'b1;
                end
            end
            ST_LOCK: begin
                if (bus.sfx_clear) begin
                    state_d = ST_CLR0;
                    restart = 1'b1;
                end else if (bus.sfx_lock) begin
                    state_d = ST_LOCK;
                    restart = 1'b1;
                end else if (step_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR0: begin
                if (bus.sfx_clear) begin
                    state_d = ST_CLR0;
                    restart = 1'b1;
                end else if (step_done) begin
                    state_d = ST_CLR1;
                end
            end
            ST_CLR1: begin
                if (bus.sfx_clear) begin
                    state_d = ST_CLR0;
                    restart = 1'b1;
                end else if (step_done) begin
                    state_d = ST_CLR2;
                end
            end
            ST_CLR2: begin
                if (bus.sfx_clear) begin
                    state_d = ST_CLR0;
                    restart = 1'b1;
                end else if (step_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        note_change = restart || (state_d != state_q);
    end

    // ------------------------------------------------------------------
    // Timebase and tone generation
    // ------------------------------------------------------------------
    // 1 ms divider; realigned on each fresh effect so the first note is exactly N ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Millisecond counter for the current note.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms_cnt <= '0;
        end else if (note_change || (state_q == ST_IDLE)) begin
            ms_cnt <= '0;
        end else if (tick) begin
            ms_cnt <= ms_cnt + MS_W'(1);
        end
    end

    // Effect square wave; phase restarts at every note change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_cnt <= '0;
            sfx_sq   <= 1'b0;
        end else if (note_change || (state_q == ST_IDLE)) begin
            tone_cnt <= '0;
            sfx_sq   <= 1'b0;
        end else if (tone_cnt == hp_last) begin
            tone_cnt <= '0;
            sfx_sq   <= ~sfx_sq;
        end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Volume and output stage
    // ------------------------------------------------------------------
    // Free-running 7-phase PWM counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
        end
    end

    // Source select (effects duck the melody) and volume gate.
    always_comb begin
        tone = (state_q != ST_IDLE) ? sfx_sq : bus.melody_in;
        gate = (pwm_cnt < bus.volume);
    end

    // Registered speaker drive and effect-active flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spkr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            spkr_q   <= ~bus.mute & gate & tone;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign bus.spkr_out   = spkr_q;
    assign bus.sfx_active = active_q;

endmodule

// File: tb/tb_sfx_mixer.sv
// Bench for sfx_mixer. Runs at FCLK = 100 kHz (1 ms = 100 cycles) with
// LOCK_MS = 10 and STEP_MS = 8, so lock = 1000 cycles, each arpeggio note =
// 800 cycles. Half-periods: 220 Hz -> 227, 523 -> 95, 659 -> 75, 784 -> 63.
// Stimulus pushes each expected output change (cycle, spkr_out, sfx_active)
// into a queue; the monitor pops one entry every time the outputs change.
module tb_sfx_mixer;

    localparam int FCLK    = 100_000;
    localparam int LOCK_MS = 10;
    localparam int STEP_MS = 8;

    localparam int LOCK_CYC = 1000;
    localparam int STEP_CYC = 800;
    localparam int HP_LOCK  = 227;
    localparam int HP_C0    = 95;
    localparam int HP_C1    = 75;
    localparam int HP_C2    = 63;

    typedef struct {
        int    cyc;
        logic  spkr;
        logic  act;
        string name;
    } evt_t;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b0;
    int     cyc     = 0;
    bit     mon_en  = 1'b0;
    int     rel_cyc = 0;     // cycle count at the last reset release
    int     n_tests = 0;
    int     n_fail  = 0;
    evt_t   exp_q[$];

    sfx_mixer_if bus ();

    sfx_mixer #(
        .FCLK    (FCLK),
        .LOCK_MS (LOCK_MS),
        .STEP_MS (STEP_MS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_evt(input int c, input logic s, input logic a, input string name);
        evt_t e;
        e.cyc  = c;
        e.spkr = s;
        e.act  = a;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // n output toggles of an effect note whose square restarted at edge 'base'.
    task automatic tone_evts(input int base, input int hp, input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            expect_evt(base + hp * i + 1, logic'(i % 2), 1'b1, name);
        end
    endtask

    // Full arpeggio after an entry into CLR0 at edge e (start event not included).
    task automatic clear_evts(input int e, input string name);
        tone_evts(e,                HP_C0, 8,  {name, " C0"});
        tone_evts(e + STEP_CYC,     HP_C1, 10, {name, " C1"});
        tone_evts(e + 2 * STEP_CYC, HP_C2, 12, {name, " C2"});
        expect_evt(e + 3 * STEP_CYC, 1'b0, 1'b0, {name, " end"});
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input bit lock, input bit clear);
        bus.sfx_lock  = lock;
        bus.sfx_clear = clear;
        @(negedge clk);
        bus.sfx_lock  = 1'b0;
        bus.sfx_clear = 1'b0;
    endtask

    // Monitor: one scoreboard entry per output change.
    initial begin
        logic ps;
        logic pa;
        evt_t e;
        wait (mon_en);
        ps = bus.spkr_out;
        pa = bus.sfx_active;
        forever begin
            @(negedge clk);
            if ({bus.spkr_out, bus.sfx_active} !== {ps, pa}) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected change: spkr_out=%0b sfx_active=%0b at cycle %0d, nothing expected",
                             bus.spkr_out, bus.sfx_active, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, " cycle"}, cyc, e.cyc);
                    check({e.name, " {spkr,active}"}, {30'd0, bus.spkr_out, bus.sfx_active},
                          {30'd0, e.spkr, e.act});
                end
                ps = bus.spkr_out;
                pa = bus.sfx_active;
            end
        end
    end

    // Stimulus.
    initial begin
        int e;
        int e2;
        int c;
        bit m;
        int mel_len[5] = '{3, 2, 1, 1, 4};

        bus.melody_in = 1'b0;
        bus.sfx_lock  = 1'b0;
        bus.sfx_clear = 1'b0;
        bus.volume    = 3'd7;
        bus.mute      = 1'b0;

        // Reset state.
        tick_n(3);
        check("reset spkr_out", {31'd0, bus.spkr_out}, 32'd0);
        check("reset sfx_active", {31'd0, bus.sfx_active}, 32'd0);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        rel_cyc = cyc;
        tick_n(5);

        // 1) Idle pass-through, one cycle latency.
        m = 1'b0;
        foreach (mel_len[i]) begin
            m = ~m;
            bus.melody_in = m;
            expect_evt(cyc + 1, m, 1'b0, "pass");
            tick_n(mel_len[i]);
        end
        bus.melody_in = 1'b0;
        expect_evt(cyc + 1, 1'b0, 1'b0, "pass low");
        tick_n(5);

        // 2) Lock blip; melody ignored while it plays.
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "lock start");
        tone_evts(e, HP_LOCK, 4, "lock tone");
        expect_evt(e + LOCK_CYC, 1'b0, 1'b0, "lock end");
        pulse(1'b1, 1'b0);
        bus.melody_in = 1'b1;
        tick_n(500);
        bus.melody_in = 1'b0;
        wait_cyc(e + LOCK_CYC + 100);

        // Lock retrigger restarts the blip from scratch.
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "relock start");
        expect_evt(e + 228, 1'b1, 1'b1, "relock first tone");
        pulse(1'b1, 1'b0);
        wait_cyc(e + 299);
        e2 = cyc + 1;
        expect_evt(e2 + 1, 1'b0, 1'b1, "relock phase reset");
        tone_evts(e2, HP_LOCK, 4, "relock tone");
        expect_evt(e2 + LOCK_CYC, 1'b0, 1'b0, "relock end");
        pulse(1'b1, 1'b0);
        wait_cyc(e2 + LOCK_CYC + 100);

        // 3) Clear arpeggio.
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "clear start");
        clear_evts(e, "clear");
        pulse(1'b0, 1'b1);
        wait_cyc(e + 3 * STEP_CYC + 100);

        // 4) Clear preempts lock; lock ignored in CLR1; same-cycle pulses pick clear.
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "prio lock start");
        tone_evts(e, HP_LOCK, 2, "prio lock tone");
        pulse(1'b1, 1'b0);
        wait_cyc(e + 499);
        e2 = cyc + 1;
        clear_evts(e2, "preempt");
        pulse(1'b0, 1'b1);
        wait_cyc(e2 + STEP_CYC + 149);
        pulse(1'b1, 1'b0);
        wait_cyc(e2 + 3 * STEP_CYC + 100);

        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "both start");
        clear_evts(e, "both");
        pulse(1'b1, 1'b1);
        wait_cyc(e + 3 * STEP_CYC + 100);

        // 5) Volume and mute.
        bus.melody_in = 1'b1;
        expect_evt(cyc + 1, 1'b1, 1'b0, "vol7 high");
        tick_n(3);
        while (((cyc - rel_cyc) % 7) != 0) @(negedge clk);
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            expect_evt(c + 4 + 7 * k, 1'b0, 1'b0, "vol3 fall");
            if (k < 3) expect_evt(c + 8 + 7 * k, 1'b1, 1'b0, "vol3 rise");
        end
        bus.volume = 3'd3;
        wait_cyc(c + 28);
        bus.volume = 3'd0;
        tick_n(20);
        bus.volume = 3'd7;
        expect_evt(cyc + 1, 1'b1, 1'b0, "vol7 again");
        tick_n(3);
        bus.mute = 1'b1;
        expect_evt(cyc + 1, 1'b0, 1'b0, "mute");
        tick_n(2);
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "muted lock start");
        expect_evt(e + LOCK_CYC, 1'b0, 1'b0, "muted lock end");
        pulse(1'b1, 1'b0);
        wait_cyc(e + LOCK_CYC + 2);
        bus.mute = 1'b0;
        expect_evt(cyc + 1, 1'b1, 1'b0, "unmute");
        tick_n(3);
        bus.melody_in = 1'b0;
        expect_evt(cyc + 1, 1'b0, 1'b0, "melody off");
        tick_n(3);

        // 6) Reset in the middle of CLR1, then pass-through again.
        e = cyc + 1;
        expect_evt(e, 1'b0, 1'b1, "rst clear start");
        tone_evts(e, HP_C0, 8, "rst C0");
        tone_evts(e + STEP_CYC, HP_C1, 3, "rst C1");
        expect_evt(e + 1031, 1'b0, 1'b0, "rst abort");
        pulse(1'b0, 1'b1);
        wait_cyc(e + 1030);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset spkr_out", {31'd0, bus.spkr_out}, 32'd0);
        check("async reset sfx_active", {31'd0, bus.sfx_active}, 32'd0);
        tick_n(3);
        reset_n = 1'b1;
        rel_cyc = cyc;
        tick_n(2);
        bus.melody_in = 1'b1;
        expect_evt(cyc + 1, 1'b1, 1'b0, "post-reset pass high");
        tick_n(3);
        bus.melody_in = 1'b0;
        expect_evt(cyc + 1, 1'b0, 1'b0, "post-reset pass low");
        tick_n(5);

        check("pending events", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
